// File: rtl/jam_pkg.sv
// jam_pkg: types and helpers shared by the job-assignment solver.
//   state_t : controller states
//   fact()  : constant factorial, usable in parameter expressions
//   MAX_N   : largest supported problem size
//   perm_t  : MAX_N-entry permutation, one job index per worker
package jam_pkg;

   localparam int MAX_N     = 8;
   localparam int MAX_IDX_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SUM,
      STEP,
      DONE
   } state_t;

   typedef logic [MAX_IDX_W-1:0] idx_t;
   typedef idx_t [MAX_N-1:0]     perm_t;

   function automatic int fact(input int n);
      int r;
      r = 1;
      for (int i = 2; i <= n; i++) begin
         r = r * i;
      end
      return r;
   endfunction

endpackage

// File: rtl/jam_next_perm.sv
// jam_next_perm: combinational lexicographic successor of a permutation.
//   perm_i     : current permutation, perm_i[i] = job of worker i
//   next_o     : next permutation in lexicographic order (perm_i[0] most significant)
//   has_next_o : low when perm_i is fully descending (last permutation)
module jam_next_perm
   import jam_pkg::*;
#(
   parameter  int N     = 8,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0][IDX_W-1:0] perm_i,
   output logic [N-1:0][IDX_W-1:0] next_o,
   output logic                    has_next_o
);

   logic [IDX_W-1:0]          pivot;
   logic [IDX_W-1:0]          succ;
   logic [IDX_W-1:0]          rev_idx;
   logic [N-1:0][IDX_W-1:0]   swapped;

   always_comb begin
      pivot      = '0;
      has_next_o = 1'b0;
      // Ascending scan: the last hit is the largest pivot index.
      for (int i = 0; i < N-1; i++) begin
         if (perm_i[i] < perm_i[i+1]) begin
            pivot      = IDX_W'(i);
            has_next_o = 1'b1;
         end
      end

      // Rightmost element after the pivot that is larger than it.
      succ = pivot;
      for (int j = 0; j < N; j++) begin
         if ((IDX_W'(j) > pivot) && (perm_i[j] > perm_i[pivot])) begin
            succ = IDX_W'(j);
         end
      end

      swapped        = perm_i;
      swapped[pivot] = perm_i[succ];
      swapped[succ]  = perm_i[pivot];

      // Reverse the suffix pivot+1..N-1: position j takes N+pivot-j.
      // Arithmetic wraps in IDX_W bits but the true result is always < N.
      next_o  = swapped;
      rev_idx = '0;
      for (int j = 0; j < N; j++) begin
         if (IDX_W'(j) > pivot) begin
            rev_idx   = IDX_W'(N - j) + pivot;
            next_o[j] = swapped[rev_idx];
         end
      end
   end

endmodule

// File: rtl/jam_param.sv
// jam_param: exhaustive N x N job-assignment solver.
//   CLK, RST   : clock, asynchronous active-high reset
//   start      : begin a run (accepted in IDLE or DONE only)
//   busy       : run in progress
//   W, J       : cost ROM row/column address
//   Cost       : ROM data for the address presented on the previous cycle
//   MinCost    : minimum total cost
//   MatchCount : number of permutations reaching MinCost
//   BestAssign : {perm[N-1],...,perm[0]} of the first optimal permutation
//   Valid      : results valid (level)
module jam_param
   import jam_pkg::*;
#(
   parameter  int N      = 8,
   parameter  int COST_W = 7,
   parameter  int CNT_W  = 16,
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1,
   localparam int SUM_W  = COST_W + $clog2(N)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   output logic                 busy,
   output logic [IDX_W-1:0]     W,
   output logic [IDX_W-1:0]     J,
   input  logic [COST_W-1:0]    Cost,
   output logic [SUM_W-1:0]     MinCost,
   output logic [CNT_W-1:0]     MatchCount,
   output logic [N*IDX_W-1:0]   BestAssign,
   output logic                 Valid
);

   localparam int               LC_W     = $clog2(N*N + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef logic [N-1:0][IDX_W-1:0] perm_vec_t;

   function automatic perm_vec_t identity_perm();
      perm_vec_t p;
      for (int i = 0; i < N; i++) begin
         p[i] = IDX_W'(i);
      end
      return p;
   endfunction

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    w_q, w_d, j_q, j_d;
   logic [IDX_W-1:0]    wp_q, wp_d, jp_q, jp_d;   // address issued last cycle
   logic [LC_W-1:0]     lc_q, lc_d;               // LOAD cycle index
   logic [IDX_W-1:0]    k_q, k_d;                 // SUM row index
   logic [SUM_W-1:0]    acc_q, acc_d;
   logic [SUM_W-1:0]    min_q, min_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   perm_vec_t           best_q, best_d;
   perm_vec_t           perm_q, perm_d;
   logic [COST_W-1:0]   cost_q [N][N];
   logic [COST_W-1:0]   cost_d [N][N];

   perm_vec_t           next_perm;
   logic                has_next;

   jam_next_perm #(
      .N (N)
   ) u_next_perm (
      .perm_i     (perm_q),
      .next_o     (next_perm),
      .has_next_o (has_next)
   );

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      j_d     = j_q;
      wp_d    = w_q;
      jp_d    = j_q;
      lc_d    = lc_q;
      k_d     = k_q;
      acc_d   = acc_q;
      min_d   = min_q;
      cnt_d   = cnt_q;
      best_d  = best_q;
      perm_d  = perm_q;
      cost_d  = cost_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = LOAD;
               w_d     = '0;
               j_d     = '0;
               lc_d    = '0;
               min_d   = '1;
               cnt_d   = '0;
               best_d  = identity_perm();
               perm_d  = identity_perm();
            end
         end

         LOAD: begin
            lc_d = lc_q + 1'b1;
            // Cycle 0 has nothing to capture yet; later cycles take the
            // data for the address issued one cycle earlier.
            if (lc_q != '0) begin
               cost_d[wp_q][jp_q] = Cost;
            end
            // Row-major walk, holding at the last address.
            if (j_q == LAST_IDX) begin
               if (w_q != LAST_IDX) begin
                  w_d = w_q + 1'b1;
                  j_d = '0;
               end
            end else begin
               j_d = j_q + 1'b1;
            end
            if (lc_q == LC_W'(N*N)) begin
               state_d = SUM;
               k_d     = '0;
            end
         end

         SUM: begin
            acc_d = ((k_q == '0) ? '0 : acc_q) + SUM_W'(cost_q[k_q][perm_q[k_q]]);
            if (k_q == LAST_IDX) begin
               state_d = STEP;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         STEP: begin
            if (acc_q < min_q) begin
               min_d  = acc_q;
               cnt_d  = CNT_W'(1);
               best_d = perm_q;
            end else if (acc_q == min_q) begin
               cnt_d = cnt_q + 1'b1;
            end
            k_d = '0;
            if (has_next) begin
               perm_d  = next_perm;
               state_d = SUM;
            end else begin
               state_d = DONE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         w_q     <= '0;
         j_q     <= '0;
         wp_q    <= '0;
         jp_q    <= '0;
         lc_q    <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         min_q   <= '1;
         cnt_q   <= '0;
         best_q  <= identity_perm();
         perm_q  <= identity_perm();
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               cost_q[r][c] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         j_q     <= j_d;
         wp_q    <= wp_d;
         jp_q    <= jp_d;
         lc_q    <= lc_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         min_q   <= min_d;
         cnt_q   <= cnt_d;
         best_q  <= best_d;
         perm_q  <= perm_d;
         cost_q  <= cost_d;
      end
   end

   assign busy       = (state_q == LOAD) || (state_q == SUM) || (state_q == STEP);
   assign Valid      = (state_q == DONE);
   assign W          = w_q;
   assign J          = j_q;
   assign MinCost    = min_q;
   assign MatchCount = cnt_q;
   assign BestAssign = best_q;

endmodule

// File: tb/tb_jam_param.sv
// tb_jam_param: table-driven check of jam_param at N=2, N=3 and N=6 with a
// brute-force reference model and an expected-result queue.
module tb_jam_param;
   import jam_pkg::*;

   localparam int PAT_RAMP  = 0;   // cost = i*n + j + 1
   localparam int PAT_DIAG  = 1;   // 0 on diagonal, 9 elsewhere
   localparam int PAT_ANTI  = 2;   // 1 on anti-diagonal, 50 elsewhere
   localparam int PAT_CONST = 3;   // every entry = val
   localparam int PAT_RAND  = 4;   // uniform random 0..127

   typedef struct {
      int sel;
      int pat;
      int val;
      int use_model;
      int e_min;
      int e_cnt;
      int e_asg;
      int glitch;
   } vec_t;

   typedef struct {
      int min;
      int cnt;
      int asg;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic start2 = 1'b0, start3 = 1'b0, start6 = 1'b0;

   logic [6:0] rom [8][8];
   logic [6:0] cost2, cost3, cost6;

   logic        busy2, valid2;
   logic [0:0]  w2, j2;
   logic [7:0]  min2;
   logic [15:0] cnt2;
   logic [1:0]  asg2;

   logic        busy3, valid3;
   logic [1:0]  w3, j3;
   logic [8:0]  min3;
   logic [15:0] cnt3;
   logic [5:0]  asg3;

   logic        busy6, valid6;
   logic [2:0]  w6, j6;
   logic [9:0]  min6;
   logic [15:0] cnt6;
   logic [17:0] asg6;

   int checks = 0;
   int errors = 0;
   int sel = 0;
   int run_no = 0;
   exp_t sb[$];

   logic [31:0] obs_busy, obs_valid, obs_w, obs_j, obs_min, obs_cnt, obs_asg;

   always #5 CLK = ~CLK;

   jam_param #(.N(2)) u2 (
      .CLK(CLK), .RST(RST), .start(start2), .busy(busy2), .W(w2), .J(j2),
      .Cost(cost2), .MinCost(min2), .MatchCount(cnt2), .BestAssign(asg2), .Valid(valid2)
   );
   jam_param #(.N(3)) u3 (
      .CLK(CLK), .RST(RST), .start(start3), .busy(busy3), .W(w3), .J(j3),
      .Cost(cost3), .MinCost(min3), .MatchCount(cnt3), .BestAssign(asg3), .Valid(valid3)
   );
   jam_param #(.N(6)) u6 (
      .CLK(CLK), .RST(RST), .start(start6), .busy(busy6), .W(w6), .J(j6),
      .Cost(cost6), .MinCost(min6), .MatchCount(cnt6), .BestAssign(asg6), .Valid(valid6)
   );

   // Cost ROM with one cycle of read latency.
   always @(posedge CLK) begin
      cost2 <= rom[3'(w2)][3'(j2)];
      cost3 <= rom[3'(w3)][3'(j3)];
      cost6 <= rom[w6][j6];
   end

   always_comb begin
      obs_busy = 0; obs_valid = 0; obs_w = 0; obs_j = 0;
      obs_min = 0; obs_cnt = 0; obs_asg = 0;
      case (sel)
         0: begin
            obs_busy = 32'(busy2); obs_valid = 32'(valid2); obs_w = 32'(w2); obs_j = 32'(j2);
            obs_min = 32'(min2); obs_cnt = 32'(cnt2); obs_asg = 32'(asg2);
         end
         1: begin
            obs_busy = 32'(busy3); obs_valid = 32'(valid3); obs_w = 32'(w3); obs_j = 32'(j3);
            obs_min = 32'(min3); obs_cnt = 32'(cnt3); obs_asg = 32'(asg3);
         end
         default: begin
            obs_busy = 32'(busy6); obs_valid = 32'(valid6); obs_w = 32'(w6); obs_j = 32'(j6);
            obs_min = 32'(min6); obs_cnt = 32'(cnt6); obs_asg = 32'(asg6);
         end
      endcase
   end

   function automatic int n_of(input int s);
      return (s == 0) ? 2 : (s == 1) ? 3 : 6;
   endfunction

   function automatic int idxw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int ident(input int n);
      int r;
      r = 0;
      for (int i = 0; i < n; i++) r += i << (i * idxw_of(n));
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic drive_start(input int s, input logic v);
      case (s)
         0: start2 = v;
         1: start3 = v;
         default: start6 = v;
      endcase
   endtask

   task automatic fill(input int pat, input int n, input int val);
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            case (pat)
               PAT_RAMP:  rom[i][j] = 7'(i * n + j + 1);
               PAT_DIAG:  rom[i][j] = (i == j) ? 7'd0 : 7'd9;
               PAT_ANTI:  rom[i][j] = (j == n - 1 - i) ? 7'd1 : 7'd50;
               PAT_CONST: rom[i][j] = 7'(val);
               default:   rom[i][j] = 7'($urandom_range(127, 0));
            endcase
         end
      end
   endtask

   // Enumerates every n-digit base-n tuple in increasing order (digit 0 most
   // significant), keeping only permutations; the first strict minimum seen
   // is therefore the lexicographically smallest optimum.
   function automatic exp_t model(input int n);
      exp_t e;
      int total;
      int d[8];
      e.min = 1 << 30;
      e.cnt = 0;
      e.asg = 0;
      total = 1;
      for (int i = 0; i < n; i++) total *= n;
      for (int t = 0; t < total; t++) begin
         int v;
         int used;
         int ok;
         int s;
         v = t; used = 0; ok = 1; s = 0;
         for (int i = n - 1; i >= 0; i--) begin
            d[i] = v % n;
            v = v / n;
         end
         for (int i = 0; i < n; i++) begin
            if (used[d[i]]) ok = 0;
            used = used | (1 << d[i]);
         end
         if (ok != 0) begin
            for (int i = 0; i < n; i++) s += int'(rom[i][d[i]]);
            if (s < e.min) begin
               e.min = s;
               e.cnt = 1;
               e.asg = 0;
               for (int i = 0; i < n; i++) e.asg += d[i] << (i * idxw_of(n));
            end else if (s == e.min) begin
               e.cnt++;
            end
         end
      end
      return e;
   endfunction

   task automatic check_reset(input int s);
      int n;
      n = n_of(s);
      sel = s;
      #1;
      check("rst_busy", obs_busy, 0);
      check("rst_valid", obs_valid, 0);
      check("rst_w", obs_w, 0);
      check("rst_j", obs_j, 0);
      check("rst_min", obs_min, (1 << (7 + $clog2(n))) - 1);
      check("rst_cnt", obs_cnt, 0);
      check("rst_assign", obs_asg, ident(n));
   endtask

   // One full run: push expectation, start, check address walk and latency,
   // then pop and compare results. glitch>0 pulses start at that edge count.
   task automatic run_case(input int s, input exp_t e_in, input int glitch);
      exp_t e;
      int n;
      int lat;
      int edges;
      int bad;
      int ew;
      int ej;
      n = n_of(s);
      lat = 1 + (n * n + 1) + fact(n) * (n + 1);
      sel = s;
      @(negedge CLK);
      drive_start(s, 1'b1);
      sb.push_back(e_in);
      @(posedge CLK);
      edges = 1;
      #1 drive_start(s, 1'b0);
      bad = 0;
      for (int c = 0; c <= n * n; c++) begin
         @(negedge CLK);
         if (c == 0) begin
            check("busy_in_run", obs_busy, 1);
            check("valid_drop", obs_valid, 0);
         end
         ew = (c < n * n) ? c / n : n - 1;
         ej = (c < n * n) ? c % n : n - 1;
         if (obs_w !== 32'(ew) || obs_j !== 32'(ej)) bad++;
         @(posedge CLK);
         edges++;
      end
      check("addr_seq", bad, 0);
      #1;
      while (obs_valid !== 32'd1 && edges < lat + 20) begin
         drive_start(s, (edges == glitch) ? 1'b1 : 1'b0);
         @(posedge CLK);
         edges++;
         #1;
      end
      drive_start(s, 1'b0);
      check("latency", edges, lat);
      e = sb.pop_front();
      @(negedge CLK);
      check("valid_done", obs_valid, 1);
      check("busy_done", obs_busy, 0);
      check("min_cost", obs_min, e.min);
      check("match_count", obs_cnt, e.cnt);
      check("best_assign", obs_asg, e.asg);
      run_no++;
      $display("run %0d: N=%0d MinCost=%0d MatchCount=%0d BestAssign=0x%0h cycles=%0d (exp %0d/%0d/0x%0h/%0d)",
               run_no, n, obs_min, obs_cnt, obs_asg, edges, e.min, e.cnt, e.asg, lat);
   endtask

   initial begin
      vec_t vecs[11];
      exp_t e;
      int n;

      vecs[0]  = '{0, PAT_RAMP,  0,   0, 5,   2,   2,      0};
      vecs[1]  = '{1, PAT_DIAG,  0,   0, 0,   1,   36,     0};
      vecs[2]  = '{1, PAT_ANTI,  0,   0, 3,   1,   6,      0};
      vecs[3]  = '{1, PAT_RAMP,  0,   0, 15,  6,   36,     0};
      vecs[4]  = '{2, PAT_CONST, 0,   0, 0,   720, 181896, 0};
      vecs[5]  = '{2, PAT_CONST, 127, 0, 762, 720, 181896, 0};
      vecs[6]  = '{2, PAT_RAMP,  0,   0, 111, 720, 181896, 0};
      vecs[7]  = '{2, PAT_RAND,  0,   1, 0,   0,   0,      500};
      vecs[8]  = '{0, PAT_RAND,  0,   1, 0,   0,   0,      0};
      vecs[9]  = '{1, PAT_RAND,  0,   1, 0,   0,   0,      0};
      vecs[10] = '{2, PAT_RAND,  0,   1, 0,   0,   0,      0};

      fill(PAT_CONST, 8, 0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      for (int s = 0; s < 3; s++) check_reset(s);
      @(negedge CLK);
      RST = 1'b0;

      foreach (vecs[v]) begin
         n = n_of(vecs[v].sel);
         fill(vecs[v].pat, n, vecs[v].val);
         if (vecs[v].use_model != 0) begin
            e = model(n);
         end else begin
            e.min = vecs[v].e_min;
            e.cnt = vecs[v].e_cnt;
            e.asg = vecs[v].e_asg;
         end
         run_case(vecs[v].sel, e, vecs[v].glitch);
      end

      // Asynchronous reset in the middle of SUM on the N=6 engine.
      fill(PAT_RAND, 6, 0);
      sel = 2;
      @(negedge CLK);
      start6 = 1'b1;
      @(posedge CLK);
      #1 start6 = 1'b0;
      repeat (150) @(posedge CLK);
      #2 RST = 1'b1;
      check_reset(2);
      @(negedge CLK);
      RST = 1'b0;
      $display("run: N=6 reset asserted mid-SUM");

      // A clean run after the reset still solves the new matrix.
      fill(PAT_RAND, 6, 0);
      e = model(6);
      run_case(2, e, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
